// File: rtl/clk_div_cfg_ctrl.sv
// Ratio-change controller for the programmable clock divider: gates the divider
// off, waits, loads the new ratio, waits again, then re-enables it.
module clk_div_cfg_ctrl #(
   parameter int SETTLE_CYCLES = 4,
   parameter int RST_DIV       = 2,
   parameter int MAX_DIV       = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       cfg_valid,
   input  logic [7:0] cfg_div,
   output logic       cfg_ready,
   output logic       div_en,
   output logic [7:0] div_out,
   output logic       bypass,
   output logic       busy,
   output logic       cfg_err
);

   typedef enum logic [1:0] {IDLE, QUIESCE, LOAD, RESUME} state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] RST_DIV_V   = 8'(RST_DIV);
   localparam logic [7:0] MAX_DIV_V   = 8'(MAX_DIV);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] div_out_d;
   logic       div_en_d, bypass_d, cfg_err_d, cfg_ready_d, busy_d;

   // NOTE: every combinational output gets a default before the case statement,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      div_out_d = div_out;
      bypass_d  = bypass;
      div_en_d  = 1'b0;
      cfg_err_d = 1'b0;

      unique case (state_q)
         IDLE: begin
            div_en_d = run;
            if (cfg_valid) begin
               if (cfg_div > MAX_DIV_V) begin
                  cfg_err_d = 1'b1;
               end else if (cfg_div != div_out) begin
                  pending_d = cfg_div;
                  cnt_d     = 8'd0;
                  div_en_d  = 1'b0;
                  state_d   = QUIESCE;
               end
            end
         end
         QUIESCE: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SETTLE_LAST) state_d = LOAD;
         end
         LOAD: begin
            div_out_d = pending_q;
            bypass_d  = (pending_q < 8'd2);
            cnt_d     = 8'd0;
            state_d   = RESUME;
         end
         RESUME: begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == SETTLE_LAST) begin
               state_d  = IDLE;
               div_en_d = run;
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake status is registered from the next state so it lines up with it.
      cfg_ready_d = (state_d == IDLE);
      busy_d      = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         pending_q <= 8'd0;
         div_out   <= RST_DIV_V;
         bypass    <= (RST_DIV_V < 8'd2);
         div_en    <= 1'b0;
         cfg_err   <= 1'b0;
         cfg_ready <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         div_out   <= div_out_d;
         bypass    <= bypass_d;
         div_en    <= div_en_d;
         cfg_err   <= cfg_err_d;
         cfg_ready <= cfg_ready_d;
         busy      <= busy_d;
      end
   end

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: expected div_out/cfg_err events are queued
// by the stimulus and matched by an independent negedge monitor.
module tb_clk_div_cfg_ctrl;

   localparam int SETTLE = 4;
   localparam int RSTDIV = 2;
   localparam int MAXDIV = 200;

   typedef enum logic {EV_DIV, EV_ERR} ev_kind_e;
   typedef struct {
      ev_kind_e   kind;
      logic [7:0] val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready, div_en, bypass, busy, cfg_err;
   logic [7:0] div_out;

   int  n_vec  = 0;
   int  n_miss = 0;
   ev_t exp_q[$];

   clk_div_cfg_ctrl #(
      .SETTLE_CYCLES(SETTLE),
      .RST_DIV      (RSTDIV),
      .MAX_DIV      (MAXDIV)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .div_en   (div_en),
      .div_out  (div_out),
      .bypass   (bypass),
      .busy     (busy),
      .cfg_err  (cfg_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int min_v);
      n_vec++;
      if (act < min_v) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected at least %0d", name, act, min_v);
      end
   endtask

   task automatic push(input ev_kind_e k, input logic [7:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   // Present a request and hold it until accepted; returns just after the handshake edge.
   task automatic send(input logic [7:0] d);
      int waited = 0;
      cfg_valid = 1'b1;
      cfg_div   = d;
      while (!cfg_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      check($sformatf("send%0d_ready", d), cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
   endtask

   // Starting just after acceptance edge N, walk edges N..N+2S+1 against hand-derived timing.
   task automatic run_seq(input logic [7:0] old_div, input logic [7:0] new_div);
      int busy_cycles = 0;
      for (int k = 0; k <= 2*SETTLE+1; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
         end
         if (busy) busy_cycles++;
         check($sformatf("seq%0d_busy_k%0d", new_div, k), busy, (k <= 2*SETTLE));
         check($sformatf("seq%0d_ready_k%0d", new_div, k), cfg_ready, (k > 2*SETTLE));
         check($sformatf("seq%0d_en_k%0d", new_div, k), div_en, (k == 2*SETTLE+1) ? run : 1'b0);
         check($sformatf("seq%0d_div_k%0d", new_div, k), div_out, (k >= SETTLE+1) ? new_div : old_div);
         check($sformatf("seq%0d_byp_k%0d", new_div, k), bypass,
               (k >= SETTLE+1) ? (new_div < 8'd2) : (old_div < 8'd2));
      end
      check($sformatf("seq%0d_busy_cycles", new_div), busy_cycles, 2*SETTLE+1);
   endtask

   // Monitor: matches DUT output events against the queue and checks enable/ratio spacing.
   initial begin
      logic [7:0] prev_div  = 8'(RSTDIV);
      int         zero_run  = 0;
      int         post_cnt  = 0;
      bit         post_act  = 0;
      ev_t        e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_div = div_out;
            zero_run = 0;
            post_act = 0;
         end else begin
            if (cfg_err) begin
               check("err_event_expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("err_event_kind", e.kind, EV_ERR);
                  check("err_event_div", div_out, e.val);
               end
            end
            if (div_out !== prev_div) begin
               check("div_change_while_en", div_en, 0);
               check_ge("quiet_before_change", zero_run, SETTLE);
               check("div_event_expected", (exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("div_event_kind", e.kind, EV_DIV);
                  check("div_event_val", div_out, e.val);
               end
               post_act = 1;
               post_cnt = 1;
               prev_div = div_out;
            end else if (post_act) begin
               if (!div_en) post_cnt++;
               else begin
                  check_ge("quiet_after_change", post_cnt, SETTLE);
                  post_act = 0;
               end
            end
            zero_run = div_en ? 0 : zero_run + 1;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen50 = 0;
      rst       = 1'b1;
      run       = 1'b1;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;

      // Reset values
      repeat (2) @(posedge clk); #1;
      check("rst_div_out", div_out, 2);
      check("rst_bypass", bypass, 0);
      check("rst_div_en", div_en, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_err", cfg_err, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 check("rel_div_en_before_edge", div_en, 0);
      @(posedge clk); #1;
      check("rel_div_en_after_edge", div_en, 1);
      check("rel_ready", cfg_ready, 1);
      check("rel_div_out", div_out, 2);

      // Out-of-range request
      push(EV_ERR, 8'd2);
      send(8'd201);
      check("err_pulse", cfg_err, 1);
      check("err_busy", busy, 0);
      check("err_div_en", div_en, 1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("err_after%0d_err", i), cfg_err, 0);
         check($sformatf("err_after%0d_busy", i), busy, 0);
         check($sformatf("err_after%0d_en", i), div_en, 1);
         check($sformatf("err_after%0d_div", i), div_out, 2);
      end

      // Same ratio: consumed as a no-op
      send(8'd2);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            @(posedge clk); #1;
         end
         check($sformatf("noop%0d_busy", i), busy, 0);
         check($sformatf("noop%0d_en", i), div_en, 1);
         check($sformatf("noop%0d_err", i), cfg_err, 0);
         check($sformatf("noop%0d_ready", i), cfg_ready, 1);
      end

      // Normal change to 10
      push(EV_DIV, 8'd10);
      send(8'd10);
      run_seq(8'd2, 8'd10);

      // Change to 1 (bypass) with a second request held throughout the sequence
      push(EV_DIV, 8'd1);
      push(EV_DIV, 8'd7);
      send(8'd1);
      cfg_valid = 1'b1;
      cfg_div   = 8'd7;
      run_seq(8'd10, 8'd1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      run_seq(8'd1, 8'd7);

      // Reset in the middle of a change to 50
      @(posedge clk); #1;
      send(8'd50);
      repeat (2) begin
         @(posedge clk); #1;
      end
      check("mid_busy_before_rst", busy, 1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_div_out", div_out, 2);
      check("mid_rst_div_en", div_en, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", cfg_ready, 1);
      check("mid_rst_bypass", bypass, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("mid_rel_div_en", div_en, 1);
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (div_out == 8'd50) seen50 = 1;
      end
      check("mid_never_50", seen50, 0);
      check("mid_final_div", div_out, 2);
      check("mid_final_busy", busy, 0);

      repeat (3) @(posedge clk);
      check("events_all_seen", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
